// File: rtl/sram_pb_scrubber.sv
// Background parity scrubber for a single-port-pair SRAM; client traffic always has priority.
// Latency: client accesses pass through combinationally; client_read_error and the error log lag one cycle.
// Backpressure: scrub reads/fixes stall while the client occupies the needed SRAM port; clients never stall.
module sram_pb_scrubber #(
    parameter int DATA_WIDTH      = 32,
    parameter int SIZE            = 1024,
    parameter int ADDR_WIDTH      = $clog2(SIZE),
    parameter int SCRUB_INTERVAL  = 256,
    parameter int ERR_COUNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       client_read_en,
    input  logic [ADDR_WIDTH-1:0]      client_read_addr,
    output logic [DATA_WIDTH-1:0]      client_read_data,
    output logic                       client_read_error,
    input  logic                       client_write_en,
    input  logic [ADDR_WIDTH-1:0]      client_write_addr,
    input  logic [DATA_WIDTH-1:0]      client_write_data,
    output logic                       sram_read_en,
    output logic [ADDR_WIDTH-1:0]      sram_read_addr,
    input  logic [DATA_WIDTH-1:0]      sram_read_data,
    input  logic                       sram_pb_error,
    output logic                       sram_write_en,
    output logic [ADDR_WIDTH-1:0]      sram_write_addr,
    output logic [DATA_WIDTH-1:0]      sram_write_data,
    input  logic                       scrub_enable,
    input  logic                       err_clear,
    output logic                       err_valid,
    output logic [ADDR_WIDTH-1:0]      err_addr,
    output logic [ERR_COUNT_WIDTH-1:0] err_count
);

    localparam int TIMER_WIDTH = $clog2(SCRUB_INTERVAL);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(SCRUB_INTERVAL - 1);
    localparam logic [ADDR_WIDTH-1:0]  PTR_LAST   = ADDR_WIDTH'(SIZE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FIX     = 2'd2
    } state_t;

    state_t                  state;
    logic [TIMER_WIDTH-1:0]  timer;
    logic [ADDR_WIDTH-1:0]   scrub_ptr;
    logic [ADDR_WIDTH-1:0]   ptr_next;
    logic                    scrub_rd;
    logic                    scrub_wr;
    logic                    fix_cancel;
    logic                    client_err;
    logic                    scrub_err;
    logic                    any_err;

    // A scrub read may only use the read port when the client is not reading, and must not
    // race a client write to the very word it is about to check.
    assign ptr_next   = (scrub_ptr == PTR_LAST) ? '0 : scrub_ptr + ADDR_WIDTH'(1);
    assign scrub_rd   = (state == PENDING) && scrub_enable && !client_read_en &&
                        !(client_write_en && (client_write_addr == scrub_ptr));
    assign scrub_wr   = (state == FIX) && !client_write_en;
    // A client write to the faulty word replaces its contents, so the zeroing fix is moot.
    assign fix_cancel = (state == FIX) && client_write_en && (client_write_addr == scrub_ptr);

    assign client_err = client_read_en & sram_pb_error;
    assign scrub_err  = scrub_rd & sram_pb_error;
    assign any_err    = client_err | scrub_err;

    // Enables are forced low during reset so nothing reaches the SRAM, even client traffic.
    assign sram_read_en     = reset_n & (client_read_en | scrub_rd);
    assign sram_read_addr   = client_read_en ? client_read_addr : scrub_ptr;
    assign sram_write_en    = reset_n & (client_write_en | scrub_wr);
    assign sram_write_addr  = client_write_en ? client_write_addr : scrub_ptr;
    assign sram_write_data  = client_write_en ? client_write_data : '0;
    assign client_read_data = sram_read_data;

    // Scrub sequencer: wait out the interval, read the next word, zero it if parity failed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= '0;
            scrub_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!scrub_enable) begin
                        timer <= '0;
                    end else if (timer == TIMER_LAST) begin
                        timer <= '0;
                        state <= PENDING;
                    end else begin
                        timer <= timer + TIMER_WIDTH'(1);
                    end
                end
                PENDING: begin
                    if (!scrub_enable) begin
                        state <= IDLE;
                    end else if (scrub_rd) begin
                        if (sram_pb_error) begin
                            state <= FIX;
                        end else begin
                            scrub_ptr <= ptr_next;
                            state     <= IDLE;
                        end
                    end
                end
                FIX: begin
                    if (scrub_wr || fix_cancel) begin
                        scrub_ptr <= ptr_next;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Error log: first failing address since clear plus a saturating count; a new error beats a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            client_read_error <= 1'b0;
            err_valid         <= 1'b0;
            err_addr          <= '0;
            err_count         <= '0;
        end else begin
            client_read_error <= client_err;
            if (any_err) begin
                err_valid <= 1'b1;
                if (err_clear || !err_valid) begin
                    err_addr <= sram_read_addr;
                end
                if (err_clear) begin
                    err_count <= ERR_COUNT_WIDTH'(1);
                end else if (err_count != '1) begin
                    err_count <= err_count + ERR_COUNT_WIDTH'(1);
                end
            end else if (err_clear) begin
                err_valid <= 1'b0;
                err_addr  <= '0;
                err_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_pb_scrubber.sv
// Directed bench for sram_pb_scrubber: small SRAM (16 words), short interval, 2-bit error counter.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Expected values are hand-derived cycle counts and addresses.
module tb_sram_pb_scrubber;

    localparam int DW = 8;
    localparam int SZ = 16;
    localparam int AW = 4;
    localparam int SI = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          client_read_en;
    logic [AW-1:0] client_read_addr;
    logic [DW-1:0] client_read_data;
    logic          client_read_error;
    logic          client_write_en;
    logic [AW-1:0] client_write_addr;
    logic [DW-1:0] client_write_data;
    logic          sram_read_en;
    logic [AW-1:0] sram_read_addr;
    logic [DW-1:0] sram_read_data;
    logic          sram_pb_error;
    logic          sram_write_en;
    logic [AW-1:0] sram_write_addr;
    logic [DW-1:0] sram_write_data;
    logic          scrub_enable;
    logic          err_clear;
    logic          err_valid;
    logic [AW-1:0] err_addr;
    logic [CW-1:0] err_count;

    int errors = 0;
    int checks = 0;

    sram_pb_scrubber #(
        .DATA_WIDTH(DW), .SIZE(SZ), .SCRUB_INTERVAL(SI), .ERR_COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .client_read_en(client_read_en), .client_read_addr(client_read_addr),
        .client_read_data(client_read_data), .client_read_error(client_read_error),
        .client_write_en(client_write_en), .client_write_addr(client_write_addr),
        .client_write_data(client_write_data),
        .sram_read_en(sram_read_en), .sram_read_addr(sram_read_addr),
        .sram_read_data(sram_read_data), .sram_pb_error(sram_pb_error),
        .sram_write_en(sram_write_en), .sram_write_addr(sram_write_addr),
        .sram_write_data(sram_write_data),
        .scrub_enable(scrub_enable), .err_clear(err_clear),
        .err_valid(err_valid), .err_addr(err_addr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        client_read_en    = 1'b0;
        client_read_addr  = '0;
        client_write_en   = 1'b0;
        client_write_addr = '0;
        client_write_data = '0;
        sram_read_data    = '0;
        sram_pb_error     = 1'b0;
        scrub_enable      = 1'b0;
        err_clear         = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Wait (bounded) for the next scrubber-owned read, check its address, optionally fail its parity.
    task automatic scrub_read(input int exp_addr, input bit inject);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(sram_read_en && !client_read_en) && n < 20);
        chk("scrub_rd_seen", 32'(sram_read_en), 32'd1);
        chk("scrub_rd_addr", 32'(sram_read_addr), 32'(exp_addr));
        sram_pb_error = inject;
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        client_read_en  = 1'b1;
        client_write_en = 1'b1;
        #1;
        chk("rst_rd_en", 32'(sram_read_en), 32'd0);
        chk("rst_wr_en", 32'(sram_write_en), 32'd0);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        chk("rst_err_addr", 32'(err_addr), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_cli_err", 32'(client_read_error), 32'd0);
        client_read_en  = 1'b0;
        client_write_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Periodic scrub: one read every 5 cycles, addresses 0..15 then wrap to 0.
        for (int c = 0; c < 17 * 5; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0) scrub_enable = 1'b1;
            #1;
            chk("per_wr_en", 32'(sram_write_en), 32'd0);
            if (c % 5 == 4) begin
                chk("per_rd_en", 32'(sram_read_en), 32'd1);
                chk("per_rd_addr", 32'(sram_read_addr), 32'((c / 5) % SZ));
            end else begin
                chk("per_rd_idle", 32'(sram_read_en), 32'd0);
            end
        end

        // Parity error on scrub of address 7 -> zero-write next cycle and error logged.
        do_reset();
        scrub_enable = 1'b1;
        for (int a = 0; a < 7; a++) scrub_read(a, 1'b0);
        scrub_read(7, 1'b1);
        @(negedge clk);
        sram_pb_error = 1'b0;
        #1;
        chk("fix_wr_en", 32'(sram_write_en), 32'd1);
        chk("fix_wr_addr", 32'(sram_write_addr), 32'd7);
        chk("fix_wr_data", 32'(sram_write_data), 32'd0);
        chk("fix_rd_en", 32'(sram_read_en), 32'd0);
        chk("fix_err_valid", 32'(err_valid), 32'd1);
        chk("fix_err_addr", 32'(err_addr), 32'd7);
        chk("fix_err_count", 32'(err_count), 32'd1);
        chk("fix_cli_err", 32'(client_read_error), 32'd0);
        scrub_read(8, 1'b0);

        // FIX on 3: client write elsewhere stalls it, client write to 3 cancels it.
        do_reset();
        scrub_enable = 1'b1;
        for (int a = 0; a < 3; a++) scrub_read(a, 1'b0);
        scrub_read(3, 1'b1);
        @(negedge clk);
        sram_pb_error     = 1'b0;
        client_write_en   = 1'b1;
        client_write_addr = 4'd10;
        client_write_data = 8'h5A;
        #1;
        chk("stall_wr_addr", 32'(sram_write_addr), 32'd10);
        chk("stall_wr_data", 32'(sram_write_data), 32'h5A);
        @(negedge clk);
        client_write_addr = 4'd3;
        client_write_data = 8'hA5;
        #1;
        chk("cancel_wr_addr", 32'(sram_write_addr), 32'd3);
        chk("cancel_wr_data", 32'(sram_write_data), 32'hA5);
        @(negedge clk);
        client_write_en = 1'b0;
        #1;
        chk("cancel_no_wr", 32'(sram_write_en), 32'd0);
        scrub_read(4, 1'b0);

        // Client read held across PENDING; write-to-ptr blocks; disable in PENDING.
        do_reset();
        sram_read_data   = 8'hC3;
        scrub_enable     = 1'b1;
        client_read_en   = 1'b1;
        client_read_addr = 4'd9;
        #1;
        chk("cli_rd_data", 32'(client_read_data), 32'hC3);
        chk("hold_rd_addr", 32'(sram_read_addr), 32'd9);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("hold_rd_addr", 32'(sram_read_addr), 32'd9);
        end
        @(negedge clk);
        client_read_en = 1'b0;
        #1;
        chk("rel_rd_en", 32'(sram_read_en), 32'd1);
        chk("rel_rd_addr", 32'(sram_read_addr), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("gap_rd_en", 32'(sram_read_en), 32'd0);
        end
        @(negedge clk);
        client_write_en   = 1'b1;
        client_write_addr = 4'd1;
        #1;
        chk("wblk_rd_en", 32'(sram_read_en), 32'd0);
        @(negedge clk);
        client_write_en = 1'b0;
        #1;
        chk("wblk_rel_rd_en", 32'(sram_read_en), 32'd1);
        chk("wblk_rel_addr", 32'(sram_read_addr), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("gap2_rd_en", 32'(sram_read_en), 32'd0);
        end
        @(negedge clk);
        scrub_enable = 1'b0;
        #1;
        chk("dis_pend_rd_en", 32'(sram_read_en), 32'd0);
        @(negedge clk);
        scrub_enable = 1'b1;
        #1;
        chk("reen_rd_en", 32'(sram_read_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("reen_gap_rd_en", 32'(sram_read_en), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("reen_rd_en2", 32'(sram_read_en), 32'd1);
        chk("reen_rd_addr", 32'(sram_read_addr), 32'd2);

        // Error log: client error @5, scrub error @9, clear+error @12, plain clear.
        do_reset();
        @(negedge clk);
        client_read_en   = 1'b1;
        client_read_addr = 4'd5;
        sram_pb_error    = 1'b1;
        @(negedge clk);
        client_read_en = 1'b0;
        sram_pb_error  = 1'b0;
        #1;
        chk("cerr_flag", 32'(client_read_error), 32'd1);
        chk("cerr_valid", 32'(err_valid), 32'd1);
        chk("cerr_addr", 32'(err_addr), 32'd5);
        chk("cerr_count", 32'(err_count), 32'd1);
        @(negedge clk);
        #1;
        chk("cerr_flag_drop", 32'(client_read_error), 32'd0);
        scrub_enable = 1'b1;
        for (int a = 0; a < 9; a++) scrub_read(a, 1'b0);
        scrub_read(9, 1'b1);
        @(negedge clk);
        sram_pb_error = 1'b0;
        scrub_enable  = 1'b0;
        #1;
        chk("serr_addr", 32'(err_addr), 32'd5);
        chk("serr_count", 32'(err_count), 32'd2);
        chk("serr_fix_wr", 32'(sram_write_en), 32'd1);
        chk("serr_fix_addr", 32'(sram_write_addr), 32'd9);
        @(negedge clk);
        err_clear        = 1'b1;
        client_read_en   = 1'b1;
        client_read_addr = 4'd12;
        sram_pb_error    = 1'b1;
        @(negedge clk);
        err_clear      = 1'b0;
        client_read_en = 1'b0;
        sram_pb_error  = 1'b0;
        #1;
        chk("clr_err_valid", 32'(err_valid), 32'd1);
        chk("clr_err_addr", 32'(err_addr), 32'd12);
        chk("clr_err_count", 32'(err_count), 32'd1);
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        #1;
        chk("clr_valid0", 32'(err_valid), 32'd0);
        chk("clr_addr0", 32'(err_addr), 32'd0);
        chk("clr_count0", 32'(err_count), 32'd0);

        // Five client errors saturate a 2-bit counter at 3; first address kept.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            client_read_en   = 1'b1;
            client_read_addr = AW'(i + 1);
            sram_pb_error    = 1'b1;
        end
        @(negedge clk);
        client_read_en = 1'b0;
        sram_pb_error  = 1'b0;
        #1;
        chk("sat_count", 32'(err_count), 32'd3);
        chk("sat_addr", 32'(err_addr), 32'd1);
        chk("sat_valid", 32'(err_valid), 32'd1);

        // Reset pulse during FIX: everything clears, no write, pointer back to 0.
        scrub_enable = 1'b1;
        scrub_read(10, 1'b1);
        @(negedge clk);
        sram_pb_error = 1'b0;
        reset_n       = 1'b0;
        #1;
        chk("rfix_wr_en", 32'(sram_write_en), 32'd0);
        chk("rfix_rd_en", 32'(sram_read_en), 32'd0);
        chk("rfix_err_valid", 32'(err_valid), 32'd0);
        chk("rfix_err_addr", 32'(err_addr), 32'd0);
        chk("rfix_err_count", 32'(err_count), 32'd0);
        chk("rfix_cli_err", 32'(client_read_error), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rfix_post_wr_en", 32'(sram_write_en), 32'd0);
        scrub_read(0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_pb_scrubber.md
SRAM_PB_SCRUBBER -- requirements
Module: sram_pb_scrubber

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, SRAM word width; SIZE, default 1024, SRAM depth; ADDR_WIDTH, default $clog2(SIZE), address width; SCRUB_INTERVAL, default 256, idle cycles between scrub reads (≥2); ERR_COUNT_WIDTH, default 8, error counter width.
REQ-002 SHALL have ports (name  direction  width  meaning):
 clk  in  1  single clock, all state on rising edge
 reset_n  in  1  asynchronous, active-low reset
 client_read_en  in  1  client read request
 client_read_addr  in  ADDR_WIDTH  client read address
 client_read_data  out  DATA_WIDTH  read data, cycle after request
 client_read_error  out  1  parity error on client read, aligned with data
 client_write_en  in  1  client write request
 client_write_addr  in  ADDR_WIDTH  client write address
 client_write_data  in  DATA_WIDTH  client write data
 sram_read_en  out  1  to parity SRAM read_en
 sram_read_addr  out  ADDR_WIDTH  to parity SRAM read_addr
 sram_read_data  in  DATA_WIDTH  from parity SRAM, one cycle after read_en
 sram_pb_error  in  1  parity error, valid in same cycle as sram_read_en
 sram_write_en  out  1  to parity SRAM write_en
 sram_write_addr  out  ADDR_WIDTH  to parity SRAM write_addr
 sram_write_data  out  DATA_WIDTH  to parity SRAM write_data
 scrub_enable  in  1  enables background scrubbing
 err_clear  in  1  clears error log
 err_valid  out  1  at least one error logged since clear
 err_addr  out  ADDR_WIDTH  address of first error since clear
 err_count  out  ERR_COUNT_WIDTH  saturating error count since clear

Function
REQ-003 SHALL give client priority: client reads/writes pass combinationally to SRAM ports every cycle they are asserted.
REQ-004 SHALL drive client_read_data = sram_read_data combinationally; client_read_error = registered (sram_pb_error & client_read_en), one-cycle latency.
REQ-005 SHALL implement FSM IDLE, PENDING, FIX, with scrub pointer scrub_ptr (ADDR_WIDTH) and interval timer.
REQ-006 IDLE: timer increments while scrub_enable=1; at SCRUB_INTERVAL-1 → PENDING, timer to 0; scrub_enable=0 holds timer at 0.
REQ-007 PENDING: issue scrub read of scrub_ptr in the first cycle with client_read_en=0 and NOT (client_write_en & client_write_addr==scrub_ptr); otherwise stall.
REQ-008 On scrub read cycle: sram_pb_error=1 → FIX; else scrub_ptr increments, → IDLE.
REQ-009 FIX: issue write of all-zeros to scrub_ptr in first cycle with client_write_en=0, then scrub_ptr increments, → IDLE.
REQ-010 FIX: client write to scrub_ptr SHALL cancel the fix (no scrubber write), scrub_ptr increments, → IDLE.
REQ-011 scrub_ptr SHALL wrap SIZE-1 → 0.
REQ-012 scrub_enable deasserted in PENDING → IDLE without reading; in FIX the fix SHALL complete.
REQ-013 Any detected error (client or scrub read) SHALL: set err_valid; capture err_addr only if err_valid was 0; increment err_count, saturating at all-ones.
REQ-014 err_clear SHALL zero err_valid/err_addr/err_count; an error in same cycle wins: err_valid=1, err_addr=that address, err_count=1.
REQ-015 SHALL never issue a scrubber read and client read, or scrubber write and client write, in the same cycle.

Reset
REQ-016 reset_n=0 SHALL asynchronously set FSM=IDLE, timer=0, scrub_ptr=0, client_read_error=0, err_valid=0, err_addr=0, err_count=0; sram_read_en/sram_write_en low while in reset.
REQ-017 Reset during FIX SHALL abandon the fix with no write issued.

Verification
REQ-018 SCRUB_INTERVAL=4, scrub_enable=1, no client traffic, no errors -> scrub reads at addr 0,1,2,... every 5 cycles; after SIZE reads address wraps to 0.
REQ-019 Inject sram_pb_error on scrub read of addr 7 -> next cycle sram_write_en=1, addr 7, data 0; err_valid=1, err_addr=7, err_count=1.
REQ-020 Scrub PENDING with client_read_en held 10 cycles -> no scrub read during those cycles; scrub read issued in the first cycle client_read_en=0.
REQ-021 FIX pending on addr 3 while client writes addr 3 -> no scrubber write; scrub_ptr advances to 4.
REQ-022 Client read error at addr 5, then scrub error at addr 9 -> err_addr=5, err_count=2; err_clear with simultaneous error at 12 -> err_addr=12, err_count=1.
REQ-023 ERR_COUNT_WIDTH=2, 5 errors -> err_count saturates at 3; reset_n pulse mid-FIX -> all outputs zero, no write issued.
